// File: rtl/alu_issue.sv
// ID/EX issue stage: resolves EX/MEM operand forwarding, stalls on load-use,
// and holds a registered ALU operand pair until the execute stage takes it.
module alu_issue #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int ALU_OP_WIDTH = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [REG_AW-1:0]       i_rs1_addr,
  input  logic [REG_AW-1:0]       i_rs2_addr,
  input  logic [REG_AW-1:0]       i_rd_addr,
  input  logic [XLEN-1:0]         i_rs1_data,
  input  logic [XLEN-1:0]         i_rs2_data,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [XLEN-1:0]         i_imm,
  input  logic                    i_a_sel,
  input  logic                    i_b_sel,
  input  logic [ALU_OP_WIDTH-1:0] i_op,
  input  logic                    i_wen,
  input  logic                    i_ex_valid,
  input  logic                    i_ex_wen,
  input  logic                    i_ex_is_load,
  input  logic [REG_AW-1:0]       i_ex_rd,
  input  logic [XLEN-1:0]         i_ex_data,
  input  logic                    i_mem_valid,
  input  logic                    i_mem_wen,
  input  logic [REG_AW-1:0]       i_mem_rd,
  input  logic [XLEN-1:0]         i_mem_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_a,
  output logic [XLEN-1:0]         o_b,
  output logic [ALU_OP_WIDTH-1:0] o_op,
  output logic [REG_AW-1:0]       o_rd_addr,
  output logic                    o_wen,
  output logic [XLEN-1:0]         o_store_data,
  output logic [CNT_WIDTH-1:0]    o_stall_cnt
);

  logic                    valid_q, valid_d;
  logic [XLEN-1:0]         a_q, a_d;
  logic [XLEN-1:0]         b_q, b_d;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  logic [REG_AW-1:0]       rd_q, rd_d;
  logic                    wen_q, wen_d;
  logic [XLEN-1:0]         sd_q, sd_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic            hazard;
  logic            ready;
  logic            accept;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // EX result wins over MEM because it is the younger producer.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf_data
  );
    if (rs == '0)
      return '0;
    else if (i_ex_valid && i_ex_wen && (i_ex_rd == rs))
      return i_ex_data;
    else if (i_mem_valid && i_mem_wen && (i_mem_rd == rs))
      return i_mem_data;
    else
      return rf_data;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_sel(i_rs1_addr, i_rs1_data);
    fwd_rs2 = fwd_sel(i_rs2_addr, i_rs2_data);
    // Both sources are checked even when pc/imm is selected, to keep the check cheap.
    hazard  = i_valid && i_ex_valid && i_ex_wen && i_ex_is_load && (i_ex_rd != '0) &&
              ((i_ex_rd == i_rs1_addr) || (i_ex_rd == i_rs2_addr));
    ready   = (!valid_q || i_ready) && !hazard && !i_flush;
    accept  = i_valid && ready;
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;

    if (i_flush) begin
      valid_d = 1'b0;
      wen_d   = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      a_d     = i_a_sel ? i_pc : fwd_rs1;
      b_d     = i_b_sel ? i_imm : fwd_rs2;
      op_d    = i_op;
      rd_d    = i_rd_addr;
      wen_d   = i_wen;
      sd_d    = fwd_rs2;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (hazard && !i_flush && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      sd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready      = ready;
  assign o_valid      = valid_q;
  assign o_a          = a_q;
  assign o_b          = b_q;
  assign o_op         = op_q;
  assign o_rd_addr    = rd_q;
  assign o_wen        = wen_q;
  assign o_store_data = sd_q;
  assign o_stall_cnt  = cnt_q;

endmodule
